// File: rtl/pzbcm_async_fifo_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pzbcm_async_fifo_core_if                                         |
// | Brief   : Push/pop handshake and status bundle for pzbcm_async_fifo_core.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pzbcm_async_fifo_core_if #(
  parameter int WIDTH = 8
);
  logic             i_push;
  logic [WIDTH-1:0] i_data;
  logic             o_full;
  logic             o_almost_full;
  logic             i_pop;
  logic             o_empty;
  logic [WIDTH-1:0] o_data;

  modport master (
    output i_push, i_data, i_pop,
    input  o_full, o_almost_full, o_empty, o_data
  );

  modport slave (
    input  i_push, i_data, i_pop,
    output o_full, o_almost_full, o_empty, o_data
  );
endinterface
`default_nettype wire

// File: rtl/pzbcm_async_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pzbcm_async_fifo_core                                            |
// | Brief   : Gray-pointer FIFO with synchronized status; optional internal    |
// |           reset synchronizer enabled by PZBCM_ASYNC_FIFO_RESET_SYNC_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pzbcm_async_fifo_core #(
  parameter int WIDTH                 = 8,
  parameter int DEPTH                 = 8,
  parameter int STAGES                = 2,
  parameter int ALMOST_FULL_THRESHOLD = DEPTH - 2,
  parameter int USE_OUT_DATA_RESET    = 0,
  parameter int RESET_SYNC_STAGES     = 2
)(
  input wire                     i_clk,
  input wire                     i_rst,
  pzbcm_async_fifo_core_if.slave bus
);
  localparam int              c_AW    = $clog2(DEPTH);
  localparam int              c_PW    = c_AW + 1;
  localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);
  localparam logic [c_PW-1:0] c_AF_TH = c_PW'(ALMOST_FULL_THRESHOLD);

  function automatic logic [c_PW-1:0] f_bin2gray(input logic [c_PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_PW-1:0] f_gray2bin(input logic [c_PW-1:0] g);
    logic [c_PW-1:0] b;
    b[c_PW-1] = g[c_PW-1];
    for (int i = c_PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  generate
    if ((DEPTH < 4) || (STAGES < 2) || (RESET_SYNC_STAGES < 2) || (WIDTH < 1)) begin : g_cfg_unsupported
    end
  endgenerate

  logic w_rst;

`ifdef PZBCM_ASYNC_FIFO_RESET_SYNC_EN
  logic [RESET_SYNC_STAGES-1:0] r_rst_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_sync <= '1;
    end else begin
      r_rst_sync <= {r_rst_sync[RESET_SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign w_rst = r_rst_sync[RESET_SYNC_STAGES-1];
`else
  assign w_rst = i_rst;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_PW-1:0]  r_wgray;
  logic [c_PW-1:0]  r_rgray;
  logic [c_PW-1:0]  r_wgray_sync [STAGES];
  logic [c_PW-1:0]  r_rgray_sync [STAGES];

  logic [c_PW-1:0]  w_wgray_local;
  logic [c_PW-1:0]  w_rgray_local;
  logic [c_PW-1:0]  w_wgray_rd;
  logic [c_PW-1:0]  w_rgray_wr;
  logic [c_PW-1:0]  w_wcount;
  logic             w_empty;
  logic             w_full;
  logic             w_push_en;
  logic             w_pop_en;
  logic [WIDTH-1:0] w_head;

  // Status compares the live Gray of the local pointer so full/empty assert on
  // the very next cycle; only the far side's view is delayed.
  assign w_wgray_local = f_bin2gray(r_wptr);
  assign w_rgray_local = f_bin2gray(r_rptr);
  assign w_wgray_rd    = r_wgray_sync[STAGES-1];
  assign w_rgray_wr    = r_rgray_sync[STAGES-1];

  assign w_empty   = (w_rgray_local == w_wgray_rd);
  assign w_full    = (w_wgray_local == {~w_rgray_wr[c_PW-1:c_PW-2], w_rgray_wr[c_PW-3:0]});
  assign w_push_en = bus.i_push & ~w_full;
  assign w_pop_en  = bus.i_pop & ~w_empty;
  assign w_wcount  = r_wptr - f_gray2bin(w_rgray_wr);
  assign w_head    = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_wgray <= '0;
      r_rgray <= '0;
    end else begin
      if (w_push_en) begin
        r_wptr <= r_wptr + c_ONE;
      end
      if (w_pop_en) begin
        r_rptr <= r_rptr + c_ONE;
      end
      r_wgray <= w_wgray_local;
      r_rgray <= w_rgray_local;
    end
  end

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_wgray_sync[i] <= '0;
        r_rgray_sync[i] <= '0;
      end
    end else begin
      r_wgray_sync[0] <= r_wgray;
      r_rgray_sync[0] <= r_rgray;
      for (int i = 1; i < STAGES; i++) begin
        r_wgray_sync[i] <= r_wgray_sync[i-1];
        r_rgray_sync[i] <= r_rgray_sync[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_en) begin
      r_mem[r_wptr[c_AW-1:0]] <= bus.i_data;
    end
  end

  assign bus.o_empty       = w_empty;
  assign bus.o_full        = w_full;
  assign bus.o_almost_full = (w_wcount >= c_AF_TH);

  generate
    if (USE_OUT_DATA_RESET != 0) begin : g_out_data_reset
      assign bus.o_data = w_empty ? '0 : w_head;
    end else begin : g_out_data_raw
      assign bus.o_data = w_head;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_pzbcm_async_fifo_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pzbcm_async_fifo_core                                         |
// | Brief   : Self-checking bench: vector table, corner sequences, random run. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pzbcm_async_fifo_core;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int STAGES = 2;
  localparam int AF_TH = 6;
  localparam int LAG = STAGES + 1;
`ifdef PZBCM_ASYNC_FIFO_RESET_SYNC_EN
  localparam int RST_HOLD = 2;
`else
  localparam int RST_HOLD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pzbcm_async_fifo_core_if #(.WIDTH(WIDTH)) bus ();

  pzbcm_async_fifo_core #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STAGES(STAGES), .ALMOST_FULL_THRESHOLD(AF_TH),
    .USE_OUT_DATA_RESET(1), .RESET_SYNC_STAGES(2)
  ) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: totals of accepted pushes/pops; the opposite side sees a
  // total LAG edges late, which is all the status flags depend on.
  int         m_w, m_r, m_hold;
  int         m_wh[$];
  int         m_rh[$];
  logic [7:0] m_q[$];
  logic       m_push_ok;

  function automatic int w_seen();
    return (m_wh.size() > LAG) ? m_wh[m_wh.size()-1-LAG] : 0;
  endfunction
  function automatic int r_seen();
    return (m_rh.size() > LAG) ? m_rh[m_rh.size()-1-LAG] : 0;
  endfunction
  function automatic logic m_empty();
    return m_r == w_seen();
  endfunction
  function automatic logic m_full();
    return (m_w - r_seen()) >= DEPTH;
  endfunction
  function automatic logic m_af();
    return (m_w - r_seen()) >= AF_TH;
  endfunction
  function automatic logic [7:0] m_data();
    if (m_empty()) return 8'h00;
    return m_q[0];
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_hold = RST_HOLD;
    m_q.delete(); m_wh.delete(); m_rh.delete();
  endtask

  task automatic model_edge(input logic push, input logic [7:0] d, input logic pop);
    logic ap, apop;
    m_push_ok = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_hold > 0) begin
        m_hold--;
      end else begin
        ap = push && !m_full();
        apop = pop && !m_empty();
        if (apop) begin void'(m_q.pop_front()); m_r++; end
        if (ap) begin m_q.push_back(d); m_w++; end
        m_push_ok = ap;
      end
      m_wh.push_back(m_w);
      m_rh.push_back(m_r);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".empty"}, 32'(bus.o_empty), 32'(m_empty()));
    chk({tag, ".full"}, 32'(bus.o_full), 32'(m_full()));
    chk({tag, ".almost_full"}, 32'(bus.o_almost_full), 32'(m_af()));
    chk({tag, ".data"}, 32'(bus.o_data), 32'(m_data()));
  endtask

  logic [7:0] rx[$];

  task automatic step(input logic push, input logic [7:0] d, input logic pop, input string tag);
    logic       pop_ok;
    logic [7:0] pre;
    bus.i_push = push; bus.i_data = d; bus.i_pop = pop;
    pop_ok = pop && !rst && (m_hold == 0) && !m_empty();
    pre = bus.o_data;
    @(posedge clk);
    model_edge(push, d, pop);
    if (pop_ok) rx.push_back(pre);
    @(negedge clk);
    check_outputs(tag);
  endtask

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       pop;
    logic       e, f, af;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, cyc;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    bus.i_push = 1'b0; bus.i_data = '0; bus.i_pop = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.empty", 32'(bus.o_empty), 32'd1);
    chk("reset.full", 32'(bus.o_full), 32'd0);
    chk("reset.almost_full", 32'(bus.o_almost_full), 32'd0);
    chk("reset.data", 32'(bus.o_data), 32'd0);

    // Release and push on the first three edges; only edges past the internal
    // reset hold may accept.
    rst = 1'b0;
    step(1'b1, 8'h11, 1'b0, "release1");
    step(1'b1, 8'h22, 1'b0, "release2");
    step(1'b1, 8'h33, 1'b0, "release3");
    repeat (4) step(1'b0, 8'h00, 1'b0, "release_idle");
    chk("release.first_data", 32'(bus.o_data), (RST_HOLD == 2) ? 32'h33 : 32'h11);
    repeat (8) step(1'b0, 8'h00, 1'b1, "release_drain");
    repeat (4) step(1'b0, 8'h00, 1'b0, "settle");

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].push, tbl[i].data, tbl[i].pop, "vec");
      chk($sformatf("vec%0d.empty", i), 32'(bus.o_empty), 32'(tbl[i].e));
      chk($sformatf("vec%0d.full", i), 32'(bus.o_full), 32'(tbl[i].f));
      chk($sformatf("vec%0d.almost_full", i), 32'(bus.o_almost_full), 32'(tbl[i].af));
      chk($sformatf("vec%0d.data", i), 32'(bus.o_data), 32'(tbl[i].d));
    end
    repeat (4) step(1'b0, 8'h00, 1'b0, "settle");

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i), 1'b0, "fill");
      chk($sformatf("fill%0d.almost_full", i), 32'(bus.o_almost_full), 32'(i >= 5));
      chk($sformatf("fill%0d.full", i), 32'(bus.o_full), 32'(i == 7));
    end
    step(1'b1, 8'hFF, 1'b0, "overpush");
    chk("overpush.full", 32'(bus.o_full), 32'd1);
    repeat (3) step(1'b0, 8'h00, 1'b0, "full_idle");

    rx.delete();
    step(1'b0, 8'h00, 1'b1, "pop_from_full");
    chk("pop_lat0.full", 32'(bus.o_full), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 8'h00, 1'b0, "pop_lat");
      chk($sformatf("pop_lat%0d.full", k), 32'(bus.o_full), 32'(k < 3));
    end
    repeat (14) step(1'b0, 8'h00, 1'b1, "drain");
    chk("drain.count", 32'(rx.size()), 32'd8);
    for (int i = 0; i < rx.size(); i++) chk($sformatf("drain%0d", i), 32'(rx[i]), 32'(i));

    rx.delete(); nxt = 0; cyc = 0;
    while (rx.size() < 40 && cyc < 400) begin
      step(nxt < 40, 8'(nxt), 1'b1, "stream");
      if (m_push_ok) nxt++;
      cyc++;
    end
    chk("stream.count", 32'(rx.size()), 32'd40);
    for (int i = 0; i < rx.size(); i++) chk($sformatf("stream%0d", i), 32'(rx[i]), 32'(i));

    repeat (4) step(1'b0, 8'h00, 1'b0, "settle");
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, "preload");
    repeat (4) step(1'b0, 8'h00, 1'b0, "preload_idle");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.empty", 32'(bus.o_empty), 32'd1);
    chk("midrst.full", 32'(bus.o_full), 32'd0);
    chk("midrst.almost_full", 32'(bus.o_almost_full), 32'd0);
    chk("midrst.data", 32'(bus.o_data), 32'd0);
    step(1'b0, 8'h00, 1'b0, "midrst_hold");
    rst = 1'b0;
    repeat (6) step(1'b0, 8'h00, 1'b1, "postrst_idle");
    step(1'b1, 8'h99, 1'b0, "postrst_push");
    repeat (4) step(1'b0, 8'h00, 1'b0, "postrst_wait");
    chk("postrst.data", 32'(bus.o_data), 32'h99);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 1 : 0), "random");
    end
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) == 0 ? 1 : 0), 8'($urandom), 1'($urandom_range(0, 1)), "random2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
